// File: rtl/ram_bank_arbiter.sv
// Round-robin arbiter sharing four RAM banks between NUM_REQ requesters.
// Each bank picks its own winner every cycle, so up to four accesses run
// in parallel. Commands to the banks are registered; read data returns to
// the requester three cycles after its grant.
module ram_bank_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ-1:0]                  req_write,
  input  logic [NUM_REQ*(ADDR_WIDTH+2)-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]       req_wdata,
  output logic [NUM_REQ-1:0]                  req_gnt,
  output logic [NUM_REQ-1:0]                  rsp_valid,
  output logic [NUM_REQ*DATA_WIDTH-1:0]       rsp_rdata,
  output logic [3:0]                          bank_write,
  output logic [3:0]                          bank_read,
  output logic [4*ADDR_WIDTH-1:0]             bank_wr_address,
  output logic [4*ADDR_WIDTH-1:0]             bank_rd_address,
  output logic [4*DATA_WIDTH-1:0]             bank_data_in,
  input  logic [4*DATA_WIDTH-1:0]             bank_data_out
);

  localparam int FAW = ADDR_WIDTH + 2;
  localparam int PW  = $clog2(NUM_REQ);

  logic [1:0]         req_bank [NUM_REQ];
  logic [PW-1:0]      ptr      [4];
  logic [3:0]         win_vld;
  logic [PW-1:0]      win_idx  [4];
  logic [NUM_REQ-1:0] gnt;

  genvar gi;

  // Top two address bits of each request select its bank.
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_dec
      assign req_bank[gi] = req_addr[gi*FAW+ADDR_WIDTH +: 2];
    end
  endgenerate

  // Per bank, the winning candidate is the one closest to the bank pointer
  // going upward with wrap (smallest rotated distance).
  always_comb begin
    int best;
    int rel;
    win_vld = '0;
    gnt     = '0;
    best    = 0;
    rel     = 0;
    for (int b = 0; b < 4; b++) begin
      win_idx[b] = '0;
      best       = NUM_REQ;
      for (int r = 0; r < NUM_REQ; r++) begin
        rel = (r >= int'(ptr[b])) ? (r - int'(ptr[b])) : (r + NUM_REQ - int'(ptr[b]));
        if (req_valid[r] && (req_bank[r] == 2'(b)) && (rel < best)) begin
          best       = rel;
          win_vld[b] = 1'b1;
          win_idx[b] = PW'(r);
        end
      end
      if (win_vld[b]) begin
        gnt[win_idx[b]] = 1'b1;
      end
    end
  end

  // Grants are suppressed for as long as reset is asserted.
  assign req_gnt = reset ? '0 : gnt;

  generate
    for (gi = 0; gi < 4; gi++) begin : g_bank
      logic [PW-1:0]         ptr_q, ptr_d;
      logic                  wr_q, rd_q;
      logic [ADDR_WIDTH-1:0] wa_q, ra_q;
      logic [DATA_WIDTH-1:0] din_q;
      logic                  sel_write;
      logic [ADDR_WIDTH-1:0] sel_addr;
      logic [DATA_WIDTH-1:0] sel_data;

      assign sel_write = req_write[win_idx[gi]];
      assign sel_addr  = req_addr[win_idx[gi]*FAW +: ADDR_WIDTH];
      assign sel_data  = req_wdata[win_idx[gi]*DATA_WIDTH +: DATA_WIDTH];

      // Pointer moves just past the winner whenever this bank hands off.
      always_comb begin
        ptr_d = ptr_q;
        if (win_vld[gi]) begin
          ptr_d = (int'(win_idx[gi]) == NUM_REQ - 1) ? '0 : win_idx[gi] + 1'b1;
        end
      end

      // Pointer register.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) ptr_q <= '0;
        else       ptr_q <= ptr_d;
      end

      assign ptr[gi] = ptr_q;

      // Registered bank command; address/data hold while idle.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          wr_q  <= 1'b0;
          rd_q  <= 1'b0;
          wa_q  <= '0;
          ra_q  <= '0;
          din_q <= '0;
        end else begin
          wr_q <= win_vld[gi] & sel_write;
          rd_q <= win_vld[gi] & ~sel_write;
          if (win_vld[gi] && sel_write) begin
            wa_q  <= sel_addr;
            din_q <= sel_data;
          end
          if (win_vld[gi] && !sel_write) begin
            ra_q <= sel_addr;
          end
        end
      end

      assign bank_write[gi]                               = wr_q;
      assign bank_read[gi]                                = rd_q;
      assign bank_wr_address[gi*ADDR_WIDTH +: ADDR_WIDTH] = wa_q;
      assign bank_rd_address[gi*ADDR_WIDTH +: ADDR_WIDTH] = ra_q;
      assign bank_data_in[gi*DATA_WIDTH +: DATA_WIDTH]    = din_q;
    end
  endgenerate

  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      logic                  s1_vld_q, s2_vld_q, rsp_vld_q;
      logic [1:0]            s1_bank_q, s2_bank_q;
      logic [DATA_WIDTH-1:0] rdata_q;

      // Track each read through the RAM latency, then capture its bank data.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          s1_vld_q  <= 1'b0;
          s2_vld_q  <= 1'b0;
          rsp_vld_q <= 1'b0;
          s1_bank_q <= '0;
          s2_bank_q <= '0;
          rdata_q   <= '0;
        end else begin
          s1_vld_q  <= gnt[gi] & ~req_write[gi];
          s1_bank_q <= req_bank[gi];
          s2_vld_q  <= s1_vld_q;
          s2_bank_q <= s1_bank_q;
          rsp_vld_q <= s2_vld_q;
          if (s2_vld_q) begin
            rdata_q <= bank_data_out[s2_bank_q*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end

      assign rsp_valid[gi]                          = rsp_vld_q;
      assign rsp_rdata[gi*DATA_WIDTH +: DATA_WIDTH] = rdata_q;
    end
  endgenerate

endmodule

// File: tb/tb_ram_bank_arbiter.sv
// Bench for ram_bank_arbiter with four requesters and a behavioural
// four-bank RAM attached to the bank command ports.
module tb_ram_bank_arbiter;
  localparam int NR  = 4;
  localparam int DW  = 64;
  localparam int AW  = 12;
  localparam int FAW = AW + 2;

  logic              clock = 1'b0;
  logic              reset;
  logic [NR-1:0]     req_valid, req_write;
  logic [NR*FAW-1:0] req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [NR-1:0]     req_gnt, rsp_valid;
  logic [NR*DW-1:0]  rsp_rdata;
  logic [3:0]        bank_write, bank_read;
  logic [4*AW-1:0]   bank_wr_address, bank_rd_address;
  logic [4*DW-1:0]   bank_data_in, bank_data_out;

  int total = 0;
  int bad   = 0;

  ram_bank_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_gnt(req_gnt), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .bank_write(bank_write), .bank_read(bank_read),
    .bank_wr_address(bank_wr_address), .bank_rd_address(bank_rd_address),
    .bank_data_in(bank_data_in), .bank_data_out(bank_data_out)
  );

  always #5 clock = ~clock;

  // Behavioural RAM banks: one-cycle registered read, synchronous write.
  logic [DW-1:0] mem  [4][4096];
  logic [DW-1:0] dout [4];
  assign bank_data_out = {dout[3], dout[2], dout[1], dout[0]};
  always @(posedge clock) begin
    for (int b = 0; b < 4; b++) begin
      if (bank_write[b]) mem[b][bank_wr_address[b*AW +: AW]] <= bank_data_in[b*DW +: DW];
      if (bank_read[b])  dout[b] <= mem[b][bank_rd_address[b*AW +: AW]];
    end
  end

  task automatic set_req(input int r, input logic v, input logic w,
                         input logic [FAW-1:0] a, input logic [DW-1:0] d);
    req_valid[r]            = v;
    req_write[r]            = w;
    req_addr[r*FAW +: FAW]  = a;
    req_wdata[r*DW +: DW]   = d;
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    clear_reqs();
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic drain(input int n);
    clear_reqs();
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = '1;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    @(negedge clock);
    total++;
    if (req_gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt got=%b exp=0000", req_gnt); end
    total++;
    if ({rsp_valid, rsp_rdata} !== '0) begin bad++; $display("FAIL reset_rsp got valid=%b", rsp_valid); end
    total++;
    if ({bank_write, bank_read, bank_wr_address, bank_rd_address, bank_data_in} !== '0) begin
      bad++; $display("FAIL reset_bank got wr=%b rd=%b exp=0", bank_write, bank_read);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    clear_reqs();
    @(negedge clock);
    total++;
    if ({bank_write, bank_read} !== 8'h00) begin bad++; $display("FAIL idle_strobe got wr=%b rd=%b exp=0", bank_write, bank_read); end
    $display("test_reset checked");
  endtask

  task automatic test_write_read();
    logic [DW-1:0] wd;
    wd = 64'hDEADBEEF_00000001;
    do_reset();
    set_req(0, 1'b1, 1'b1, 14'h1005, wd);
    @(negedge clock);
    total++;
    if (req_gnt !== 4'b0001) begin bad++; $display("FAIL wr_gnt got=%b exp=0001", req_gnt); end
    @(posedge clock); #1;
    set_req(0, 1'b1, 1'b0, 14'h1005, '0);
    @(negedge clock);
    total++;
    if (bank_write !== 4'b0010 || bank_wr_address[AW +: AW] !== 12'h005 || bank_data_in[DW +: DW] !== wd) begin
      bad++; $display("FAIL wr_cmd got wr=%b addr=%h data=%h exp wr=0010 addr=005 data=%h",
                      bank_write, bank_wr_address[AW +: AW], bank_data_in[DW +: DW], wd);
    end
    total++;
    if (req_gnt !== 4'b0001) begin bad++; $display("FAIL rd_gnt got=%b exp=0001", req_gnt); end
    @(posedge clock); #1;
    clear_reqs();
    @(negedge clock);
    total++;
    if (bank_read !== 4'b0010 || bank_rd_address[AW +: AW] !== 12'h005 || bank_write !== 4'b0000) begin
      bad++; $display("FAIL rd_cmd got rd=%b addr=%h wr=%b exp rd=0010 addr=005 wr=0000",
                      bank_read, bank_rd_address[AW +: AW], bank_write);
    end
    @(negedge clock);
    total++;
    if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL rsp_early got=%b exp=0000", rsp_valid); end
    @(negedge clock);
    total++;
    if (rsp_valid !== 4'b0001 || rsp_rdata[0 +: DW] !== wd) begin
      bad++; $display("FAIL rsp_data got valid=%b data=%h exp valid=0001 data=%h", rsp_valid, rsp_rdata[0 +: DW], wd);
    end
    @(negedge clock);
    total++;
    if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL rsp_pulse got=%b exp=0000", rsp_valid); end
    drain(2);
    $display("test_write_read checked");
  endtask

  task automatic test_contention();
    logic [NR-1:0] exp;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      set_req(0, 1'b1, 1'b0, 14'h2000, '0);
      set_req(1, 1'b1, 1'b0, 14'h2001, '0);
      exp = (c % 2 == 0) ? 4'b0001 : 4'b0010;
      @(negedge clock);
      total++;
      if (req_gnt !== exp) begin bad++; $display("FAIL contend_gnt cycle=%0d got=%b exp=%b", c, req_gnt, exp); end
      @(posedge clock); #1;
    end
    drain(5);
    $display("test_contention checked");
  endtask

  task automatic test_parallel();
    set_req(0, 1'b1, 1'b0, 14'h0003, '0);
    set_req(1, 1'b1, 1'b1, 14'h3007, 64'h0123_4567_89AB_CDEF);
    @(negedge clock);
    total++;
    if (req_gnt !== 4'b0011) begin bad++; $display("FAIL par_gnt got=%b exp=0011", req_gnt); end
    @(posedge clock); #1;
    clear_reqs();
    @(negedge clock);
    total++;
    if (bank_read !== 4'b0001 || bank_write !== 4'b1000) begin
      bad++; $display("FAIL par_strobe got rd=%b wr=%b exp rd=0001 wr=1000", bank_read, bank_write);
    end
    total++;
    if (bank_rd_address[0 +: AW] !== 12'h003 || bank_wr_address[3*AW +: AW] !== 12'h007 ||
        bank_data_in[3*DW +: DW] !== 64'h0123_4567_89AB_CDEF) begin
      bad++; $display("FAIL par_addr got ra0=%h wa3=%h din3=%h exp 003 007 0123456789abcdef",
                      bank_rd_address[0 +: AW], bank_wr_address[3*AW +: AW], bank_data_in[3*DW +: DW]);
    end
    drain(5);
    $display("test_parallel checked");
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] ed;
    for (int i = 0; i < 6; i++) begin
      if (i < 3) set_req(0, 1'b1, 1'b1, 14'(i), 64'(10 + i));
      else       set_req(0, 1'b1, 1'b0, 14'(i - 3), '0);
      @(negedge clock);
      total++;
      if (req_gnt !== 4'b0001) begin bad++; $display("FAIL b2b_gnt step=%0d got=%b exp=0001", i, req_gnt); end
      @(posedge clock); #1;
    end
    clear_reqs();
    for (int j = 0; j < 4; j++) begin
      @(negedge clock);
      ed = 64'(10 + j);
      total++;
      if (j < 3) begin
        if (rsp_valid !== 4'b0001 || rsp_rdata[0 +: DW] !== ed) begin
          bad++; $display("FAIL b2b_rsp idx=%0d got valid=%b data=%h exp valid=0001 data=%h", j, rsp_valid, rsp_rdata[0 +: DW], ed);
        end
      end else if (rsp_valid !== 4'b0000) begin
        bad++; $display("FAIL b2b_tail got=%b exp=0000", rsp_valid);
      end
    end
    drain(2);
    $display("test_back_to_back checked");
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    set_req(0, 1'b1, 1'b0, 14'h2010, '0);
    @(negedge clock);
    total++;
    if (req_gnt !== 4'b0001) begin bad++; $display("FAIL mid_gnt got=%b exp=0001", req_gnt); end
    @(posedge clock); #1;
    clear_reqs();
    reset = 1'b1;
    #1;
    total++;
    if ({req_gnt, rsp_valid, rsp_rdata, bank_write, bank_read, bank_wr_address, bank_rd_address, bank_data_in} !== '0) begin
      bad++; $display("FAIL mid_clear got gnt=%b rsp=%b wr=%b rd=%b exp all 0", req_gnt, rsp_valid, bank_write, bank_read);
    end
    set_req(0, 1'b1, 1'b0, 14'h2010, '0);
    @(negedge clock);
    total++;
    if (req_gnt !== 4'b0000) begin bad++; $display("FAIL mid_gnt_in_reset got=%b exp=0000", req_gnt); end
    @(posedge clock); #1;
    reset = 1'b0;
    clear_reqs();
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      total++;
      if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL mid_no_rsp cycle=%0d got=%b exp=0000", c, rsp_valid); end
      @(posedge clock); #1;
    end
    set_req(0, 1'b1, 1'b0, 14'h2000, '0);
    set_req(1, 1'b1, 1'b0, 14'h2001, '0);
    @(negedge clock);
    total++;
    if (req_gnt !== 4'b0001) begin bad++; $display("FAIL mid_ptr got=%b exp=0001", req_gnt); end
    drain(5);
    $display("test_reset_mid_read checked");
  endtask

  task automatic test_fairness();
    int cnt [NR];
    int last [NR];
    int maxgap [NR];
    do_reset();
    for (int r = 0; r < NR; r++) begin
      cnt[r] = 0; last[r] = -1; maxgap[r] = 0;
    end
    for (int c = 0; c < 12; c++) begin
      for (int r = 0; r < NR; r++) set_req(r, 1'b1, 1'b0, 14'h1000 | 14'(r), '0);
      @(negedge clock);
      total++;
      if ($countones(req_gnt) != 1) begin bad++; $display("FAIL fair_onehot cycle=%0d got=%b exp one bit", c, req_gnt); end
      for (int r = 0; r < NR; r++) begin
        if (req_gnt[r] === 1'b1) begin
          cnt[r]++;
          if (c - last[r] > maxgap[r]) maxgap[r] = c - last[r];
          last[r] = c;
        end
      end
      @(posedge clock); #1;
    end
    for (int r = 0; r < NR; r++) begin
      total++;
      if (cnt[r] != 3) begin bad++; $display("FAIL fair_count req=%0d got=%0d exp=3", r, cnt[r]); end
      total++;
      if (maxgap[r] > 4) begin bad++; $display("FAIL fair_gap req=%0d got=%0d exp<=4", r, maxgap[r]); end
    end
    drain(5);
    $display("test_fairness checked");
  endtask

  typedef struct { int due; int r; logic [DW-1:0] d; } rsp_t;

  task automatic test_random();
    localparam int N = 300;
    rsp_t          rq [$];
    rsp_t          e;
    int            mptr [4];
    logic [DW-1:0] shadow [4][4];
    logic          cv [NR];
    logic          cw [NR];
    logic [FAW-1:0] ca [NR];
    logic [DW-1:0] cd [NR];
    logic          exp_wr [4], exp_rd [4];
    logic [AW-1:0] exp_wa [4], exp_ra [4];
    logic [DW-1:0] exp_din [4];
    logic [NR-1:0] eg;
    int            win [4];
    logic          ev;
    logic [DW-1:0] ed;
    int            b, o;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      mptr[i] = 0; exp_wr[i] = 0; exp_rd[i] = 0; exp_wa[i] = '0; exp_ra[i] = '0; exp_din[i] = '0;
      for (int k = 0; k < 4; k++) shadow[i][k] = mem[i][k];
    end
    for (int r = 0; r < NR; r++) begin
      cv[r] = ($urandom_range(0, 3) != 0);
      cw[r] = 1'($urandom_range(0, 1));
      ca[r] = {2'($urandom_range(0, 3)), 10'h000, 2'($urandom_range(0, 3))};
      cd[r] = {$urandom, $urandom};
      set_req(r, cv[r], cw[r], ca[r], cd[r]);
    end
    for (int cyc = 0; cyc < N; cyc++) begin
      @(negedge clock);
      eg = '0;
      for (int bb = 0; bb < 4; bb++) begin
        win[bb] = -1;
        for (int k = 0; k < NR; k++) begin
          int r;
          r = (mptr[bb] + k) % NR;
          if (win[bb] < 0 && cv[r] && int'(ca[r][FAW-1 -: 2]) == bb) begin
            win[bb] = r;
            eg[r] = 1'b1;
          end
        end
      end
      total++;
      if (req_gnt !== eg) begin bad++; $display("FAIL rnd_gnt cycle=%0d got=%b exp=%b", cyc, req_gnt, eg); end
      for (int bb = 0; bb < 4; bb++) begin
        total++;
        if (bank_write[bb] !== exp_wr[bb] || bank_read[bb] !== exp_rd[bb] ||
            (exp_wr[bb] && (bank_wr_address[bb*AW +: AW] !== exp_wa[bb] || bank_data_in[bb*DW +: DW] !== exp_din[bb])) ||
            (exp_rd[bb] && bank_rd_address[bb*AW +: AW] !== exp_ra[bb])) begin
          bad++; $display("FAIL rnd_cmd cycle=%0d bank=%0d got wr=%b rd=%b wa=%h ra=%h exp wr=%b rd=%b wa=%h ra=%h",
                          cyc, bb, bank_write[bb], bank_read[bb], bank_wr_address[bb*AW +: AW],
                          bank_rd_address[bb*AW +: AW], exp_wr[bb], exp_rd[bb], exp_wa[bb], exp_ra[bb]);
        end
      end
      for (int r = 0; r < NR; r++) begin
        ev = 1'b0; ed = '0;
        foreach (rq[i]) if (rq[i].due == cyc && rq[i].r == r) begin ev = 1'b1; ed = rq[i].d; end
        total++;
        if (rsp_valid[r] !== ev || (ev && rsp_rdata[r*DW +: DW] !== ed)) begin
          bad++; $display("FAIL rnd_rsp cycle=%0d req=%0d got valid=%b data=%h exp valid=%b data=%h",
                          cyc, r, rsp_valid[r], rsp_rdata[r*DW +: DW], ev, ed);
        end
      end
      for (int i = rq.size() - 1; i >= 0; i--) if (rq[i].due <= cyc) rq.delete(i);
      for (int bb = 0; bb < 4; bb++) begin
        exp_wr[bb] = 1'b0;
        exp_rd[bb] = 1'b0;
        if (win[bb] >= 0) begin
          int r;
          r = win[bb];
          b = bb;
          o = int'(ca[r][1:0]);
          if (cw[r]) begin
            shadow[b][o] = cd[r];
            exp_wr[bb]   = 1'b1;
            exp_wa[bb]   = ca[r][AW-1:0];
            exp_din[bb]  = cd[r];
          end else begin
            exp_rd[bb] = 1'b1;
            exp_ra[bb] = ca[r][AW-1:0];
            e.due = cyc + 3; e.r = r; e.d = shadow[b][o];
            rq.push_back(e);
          end
          mptr[bb] = (r + 1) % NR;
        end
      end
      @(posedge clock); #1;
      for (int r = 0; r < NR; r++) begin
        if (eg[r] || !cv[r]) begin
          cv[r] = (cyc < N - 7) && ($urandom_range(0, 3) != 0);
          cw[r] = 1'($urandom_range(0, 1));
          ca[r] = {2'($urandom_range(0, 3)), 10'h000, 2'($urandom_range(0, 3))};
          cd[r] = {$urandom, $urandom};
          set_req(r, cv[r], cw[r], ca[r], cd[r]);
        end
      end
    end
    drain(2);
    $display("test_random checked");
  endtask

  initial begin
    for (int b = 0; b < 4; b++) begin
      dout[b] = '0;
      for (int a = 0; a < 4096; a++) mem[b][a] = '0;
    end
    test_reset();
    test_write_read();
    test_contention();
    test_parallel();
    test_back_to_back();
    test_reset_mid_read();
    test_fairness();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ram_bank_arbiter.md
# ram_bank_arbiter

Round-robin arbiter that shares the four-bank RAM SoC between `NUM_REQ` requesters. Each request carries a full address whose top two bits select one of the four RAM banks. The arbiter grants at most one requester per bank per cycle, so different banks can be accessed in parallel. It drives registered write and read commands into the bank `ram_if` ports and returns read data to the winning requester at a fixed latency.

## Interface
- `NUM_REQ`, 2: number of requesters, 2..8.
- `DATA_WIDTH`, 64: data width of a RAM bank.
- `ADDR_WIDTH`, 12: per-bank address width. The full request address is `ADDR_WIDTH+2` bits, and bits [ADDR_WIDTH+1:ADDR_WIDTH] select the bank.
- `clock`  in  1  single clock for all logic. One clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NUM_REQ  request valid, one bit per requester.
- `req_write`  in  NUM_REQ  1 = write, 0 = read.
- `req_addr`  in  NUM_REQ*(ADDR_WIDTH+2)  full addresses, packed with requester 0 in the LSBs.
- `req_wdata`  in  NUM_REQ*DATA_WIDTH  write data, packed.
- `req_gnt`  out  NUM_REQ  grant; a transfer completes in a cycle where `req_valid` and `req_gnt` are both high.
- `rsp_valid`  out  NUM_REQ  read data valid, one bit per requester.
- `rsp_rdata`  out  NUM_REQ*DATA_WIDTH  read data, packed.
- `bank_write`  out  4  per-bank write strobe, connects to `ram_if` write.
- `bank_read`  out  4  per-bank read strobe.
- `bank_wr_address`  out  4*ADDR_WIDTH  per-bank write address.
- `bank_rd_address`  out  4*ADDR_WIDTH  per-bank read address.
- `bank_data_in`  out  4*DATA_WIDTH  per-bank write data.
- `bank_data_out`  in  4*DATA_WIDTH  per-bank read data.

## Operation
- **Bank decode:** each valid request targets bank b = `req_addr[i][ADDR_WIDTH+1:ADDR_WIDTH]`.
- **Arbitration (combinational):**
  - For each bank, the candidates are the requesters with `req_valid` high that target that bank.
  - The winner is the first candidate found searching upward, with wrap, from that bank's pointer `ptr[b]`.
  - `req_gnt[i]` goes high for the winner of each bank that has a candidate. A requester targets only one bank, so it receives at most one grant.
- **Pointer update:** on a completed handshake at bank b, `ptr[b]` becomes (winner+1) mod NUM_REQ. A bank with no grant keeps its pointer.
- **Fairness:** a requester holding `req_valid` is granted within NUM_REQ cycles.
- **Requester rules:**
  - `req_valid`, `req_write`, `req_addr` and `req_wdata` stay stable until granted.
  - A requester may present a new request in the cycle after a grant (back-to-back issue).
- **Command stage (registered):** for each bank b with a handshake in cycle T, the command is driven during T+1:
  - Write: `bank_write[b]`=1, `bank_wr_address[b]` = low ADDR_WIDTH bits of the address, `bank_data_in[b]` = wdata.
  - Read: `bank_read[b]`=1, `bank_rd_address[b]` = low ADDR_WIDTH bits of the address.
  - Strobes are zero in any cycle with no command. Address and data hold their last value while idle.
- **Response pipeline:**
  - A read handshake in T pushes {valid, bank id} into a two-stage per-requester tracking pipe.
  - The RAM samples `read` at the end of T+1 and updates `data_out` during T+2.
  - At the end of T+2 the arbiter registers `bank_data_out[bank]` into `rsp_rdata[i]` and sets `rsp_valid[i]`=1.
  - Per requester, responses return in issue order.
- **Write/read ordering:** writes and reads to the same bank are serialized by the arbiter. A read granted in the cycle after a write to the same address returns the new data.
- **Reset:**
  - Asynchronous assertion clears every output to 0: `req_gnt`, `rsp_valid`, `rsp_rdata`, all `bank_*` strobes, addresses and data.
  - All `ptr[b]` return to 0 and the tracking pipes are cleared.
  - Reads in flight at reset produce no `rsp_valid`. `req_gnt` stays 0 while `reset` is high.

## Timing
- Grant: same cycle as `req_valid`, combinational from `req_valid`, `req_addr` and `ptr`.
- Write: bank strobe appears 1 cycle after the handshake.
- Read: `rsp_valid` rises 3 cycles after the handshake and lasts 1 cycle per read.
- Throughput: one access per bank per cycle, up to 4 concurrent accesses per cycle.
- Idle: no handshake means no strobe in the next cycle.
- Deassertion of `reset` is synchronous to `clock`. The first grant is possible in the first cycle after deassertion.

## Test plan
- **Single write then read (one requester):** req0 writes addr 0x1005 (bank 1, offset 0x005), data 0xDEADBEEF_00000001. Then req0 reads 0x1005. Required: `bank_write[1]`=1 and `bank_wr_address[1]`=0x005 one cycle after the write grant; `rsp_valid[0]`=1 with `rsp_rdata[0]`=0xDEADBEEF_00000001 three cycles after the read grant.
- **Same-bank contention:** req0 and req1 hold reads to bank 2 for 4 cycles after reset. Required: grants go req0, req1, req0, req1; only one `req_gnt` bit is high per cycle.
- **Parallel banks:** req0 reads bank 0 and req1 writes bank 3 in the same cycle. Required: both `req_gnt` bits are high; `bank_read[0]` and `bank_write[3]` are both high in the next cycle.
- **Back-to-back reads:** req0 reads offsets 0x000, 0x001 and 0x002 of bank 0 in consecutive cycles, after preloading 0xA, 0xB and 0xC. Required: `rsp_valid[0]` is high for 3 consecutive cycles with data 0xA, 0xB, 0xC in that order.
- **Reset mid-read:** assert `reset` one cycle after a read grant. Required: all outputs are 0 immediately, no `rsp_valid` ever appears for that read, and the pointer for that bank is back at req0.
- **Fairness bound:** NUM_REQ=4, all four requesters continuously request bank 1 for 12 cycles. Required: each requester is granted exactly 3 times, and no requester waits more than 4 cycles between grants.
